dff: RTL and testbench

DFF -- requirements
Module: dff

---
 rtl/dff_pkg.sv | 17 +
 rtl/dff_bit.sv | 34 +++
 rtl/dff.sv | 45 ++++
 tb/tb_dff.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/dff_pkg.sv
`default_nettype none
// ============================================================================
// Module : dff_pkg
// Desc   : Shared limits and helpers for the dff register slice.
// Rev    : 1.0 - initial release
// ============================================================================
package dff_pkg;

    localparam int unsigned DFF_MIN_WIDTH = 1;
    localparam int unsigned DFF_MAX_WIDTH = 64;

    function automatic bit dff_width_ok(input int unsigned width);
        return (width >= DFF_MIN_WIDTH) && (width <= DFF_MAX_WIDTH);
    endfunction

endpackage : dff_pkg
`default_nettype wire

// File: rtl/dff_bit.sv
`default_nettype none
// ============================================================================
// Module : dff_bit
// Desc   : Single-bit D flip-flop with synchronous, active-high reset.
// Rev    : 1.0 - initial release
// ============================================================================
module dff_bit (
    input  logic clk,
    input  logic reset,
    input  logic d,
    input  logic rst_val,
    output logic q
);

    logic state_q;
    logic state_d;

    always_comb begin
        state_d = d;
    end

    // Reset is only looked at on the rising edge; there is no asynchronous path.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= rst_val;
        end else begin
            state_q <= state_d;
        end
    end

    assign q = state_q;

endmodule : dff_bit
`default_nettype wire

// File: rtl/dff.sv
`default_nettype none
// ============================================================================
// Module : dff
// Desc   : WIDTH-bit register with synchronous reset to RESET_VAL and an
//          inverted output taken straight from the stored state.
// Rev    : 1.0 - initial release
// ============================================================================
module dff
    import dff_pkg::*;
#(
    parameter int unsigned          WIDTH     = 1,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q,
    output logic [WIDTH-1:0] o_qb
);

    generate
        if (!dff_width_ok(WIDTH)) begin : g_width_check
            $error("dff: WIDTH must be in 1..64");
        end
    endgenerate

    logic [WIDTH-1:0] bit_q;

    generate
        for (genvar gi = 0; gi < int'(WIDTH); gi++) begin : g_bit
            dff_bit u_bit (
                .clk     (clk),
                .reset   (reset),
                .d       (i_d[gi]),
                .rst_val (RESET_VAL[gi]),
                .q       (bit_q[gi])
            );
        end
    endgenerate

    assign o_q  = bit_q;
    assign o_qb = ~bit_q;

endmodule : dff
`default_nettype wire

// File: tb/tb_dff.sv
`default_nettype none
// ============================================================================
// Module : tb_dff
// Desc   : Directed and random checks of dff at WIDTH=1 and WIDTH=8.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_dff;

    logic       clk;
    logic       reset;
    logic       i_d1;
    logic       o_q1;
    logic       o_qb1;
    logic [7:0] i_d8;
    logic [7:0] o_q8;
    logic [7:0] o_qb8;

    int checks;
    int errors;

    dff #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .i_d   (i_d1),
        .o_q   (o_q1),
        .o_qb  (o_qb1)
    );

    dff #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
        .clk   (clk),
        .reset (reset),
        .i_d   (i_d8),
        .o_q   (o_q8),
        .o_qb  (o_qb8)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic test_reset();
        reset = 1'b1;
        i_d1  = 1'b1;
        i_d8  = 8'hFF;
        @(posedge clk); #1;
        checks++; if (o_q1 !== 1'b0) begin errors++; $display("FAIL reset_q1: got %b expected 0", o_q1); end
        checks++; if (o_qb1 !== 1'b1) begin errors++; $display("FAIL reset_qb1: got %b expected 1", o_qb1); end
        checks++; if (o_q8 !== 8'hA5) begin errors++; $display("FAIL reset_q8: got %h expected a5", o_q8); end
        checks++; if (o_qb8 !== 8'h5A) begin errors++; $display("FAIL reset_qb8: got %h expected 5a", o_qb8); end
        // i_d wiggles during a reset cycle must be ignored
        i_d1 = 1'b0;
        i_d8 = 8'h00;
        #4;
        i_d1 = 1'b1;
        i_d8 = 8'hFF;
        @(posedge clk); #1;
        checks++; if (o_q1 !== 1'b0) begin errors++; $display("FAIL reset_wins_q1: got %b expected 0", o_q1); end
        checks++; if (o_qb1 !== 1'b1) begin errors++; $display("FAIL reset_wins_qb1: got %b expected 1", o_qb1); end
        checks++; if (o_q8 !== 8'hA5) begin errors++; $display("FAIL reset_wins_q8: got %h expected a5", o_q8); end
    endtask

    task automatic test_capture();
        @(negedge clk);
        reset = 1'b0;
        i_d1  = 1'b1;
        i_d8  = 8'h3C;
        @(posedge clk); #1;
        checks++; if (o_q1 !== 1'b1) begin errors++; $display("FAIL capture_q1: got %b expected 1", o_q1); end
        checks++; if (o_qb1 !== 1'b0) begin errors++; $display("FAIL capture_qb1: got %b expected 0", o_qb1); end
        checks++; if (o_q8 !== 8'h3C) begin errors++; $display("FAIL capture_q8: got %h expected 3c", o_q8); end
        checks++; if (o_qb8 !== 8'hC3) begin errors++; $display("FAIL capture_qb8: got %h expected c3", o_qb8); end
        @(negedge clk);
        i_d1 = 1'b0;
        i_d8 = 8'h81;
        @(posedge clk); #1;
        checks++; if (o_q1 !== 1'b0) begin errors++; $display("FAIL capture0_q1: got %b expected 0", o_q1); end
        checks++; if (o_q8 !== 8'h81) begin errors++; $display("FAIL capture_q8b: got %h expected 81", o_q8); end
        checks++; if (o_qb8 !== 8'h7E) begin errors++; $display("FAIL capture_qb8b: got %h expected 7e", o_qb8); end
    endtask

    task automatic test_hold();
        @(negedge clk);
        i_d1 = 1'b1;
        i_d8 = 8'h55;
        @(posedge clk); #1;
        for (int k = 0; k < 6; k++) begin
            #2;
            i_d1 = ~i_d1;
            i_d8 = ~i_d8;
        end
        #2;
        checks++; if (o_q1 !== 1'b1) begin errors++; $display("FAIL hold_q1: got %b expected 1", o_q1); end
        checks++; if (o_q8 !== 8'h55) begin errors++; $display("FAIL hold_q8: got %h expected 55", o_q8); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        i_d1 = 1'b1;
        i_d8 = 8'h55;
        @(posedge clk); #1;
        #3 reset = 1'b1;
        #5 reset = 1'b0;
        #1;
        checks++; if (o_q1 !== 1'b1) begin errors++; $display("FAIL noasync_q1: got %b expected 1", o_q1); end
        checks++; if (o_q8 !== 8'h55) begin errors++; $display("FAIL noasync_q8: got %h expected 55", o_q8); end
        @(negedge clk);
        i_d8 = 8'h66;
        @(posedge clk); #1;
        checks++; if (o_q8 !== 8'h66) begin errors++; $display("FAIL noasync_next_q8: got %h expected 66", o_q8); end
    endtask

    task automatic test_reset_release();
        @(negedge clk);
        reset = 1'b1;
        i_d1  = 1'b1;
        i_d8  = 8'h3C;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            checks++; if (o_q1 !== 1'b0) begin errors++; $display("FAIL rel_hold_q1[%0d]: got %b expected 0", k, o_q1); end
            checks++; if (o_q8 !== 8'hA5) begin errors++; $display("FAIL rel_hold_q8[%0d]: got %h expected a5", k, o_q8); end
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (o_q1 !== 1'b0) begin errors++; $display("FAIL rel_pre_q1: got %b expected 0", o_q1); end
        @(posedge clk); #1;
        checks++; if (o_q1 !== 1'b1) begin errors++; $display("FAIL rel_first_q1: got %b expected 1", o_q1); end
        checks++; if (o_q8 !== 8'h3C) begin errors++; $display("FAIL rel_first_q8: got %h expected 3c", o_q8); end
        checks++; if (o_qb8 !== 8'hC3) begin errors++; $display("FAIL rel_first_qb8: got %h expected c3", o_qb8); end
    endtask

    task automatic test_random();
        logic       exp1;
        logic [7:0] exp8;
        int         err0;
        err0 = errors;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            i_d1 = 1'($urandom_range(0, 1));
            i_d8 = 8'($urandom_range(0, 255));
            exp1 = i_d1;
            exp8 = i_d8;
            @(posedge clk); #1;
            i_d1 = ~exp1;
            i_d8 = ~exp8;
            checks++; if (o_q1 !== exp1) begin errors++; if (errors - err0 < 10) $display("FAIL rand_q1[%0d]: got %b expected %b", n, o_q1, exp1); end
            checks++; if (o_qb1 !== ~exp1) begin errors++; if (errors - err0 < 10) $display("FAIL rand_qb1[%0d]: got %b expected %b", n, o_qb1, ~exp1); end
            checks++; if (o_q8 !== exp8) begin errors++; if (errors - err0 < 10) $display("FAIL rand_q8[%0d]: got %h expected %h", n, o_q8, exp8); end
            checks++; if (o_qb8 !== ~exp8) begin errors++; if (errors - err0 < 10) $display("FAIL rand_qb8[%0d]: got %h expected %h", n, o_qb8, ~exp8); end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        i_d1   = 1'b0;
        i_d8   = 8'h00;
        test_reset();
        test_capture();
        test_hold();
        test_async_reset();
        test_reset_release();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_dff
`default_nettype wire
